// File: rtl/hamming_pkg.sv
// ============================================================================
// hamming_pkg : shared Hamming(7,4) widths, bit positions and TX FSM states
// Revision    : 1.0
// ============================================================================
`default_nettype none

package hamming_pkg;

    localparam int CW_W   = 7;
    localparam int DATA_W = 4;

    // Codeword bit positions, shared with the Hamming(7,4) decoder
    localparam int D3_POS = 6;
    localparam int D2_POS = 5;
    localparam int D1_POS = 4;
    localparam int D0_POS = 3;
    localparam int P2_POS = 2;
    localparam int P1_POS = 1;
    localparam int P0_POS = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/hamming_nibble_encoder.sv
// ============================================================================
// hamming_nibble_encoder : combinational Hamming(7,4) encoder, one nibble
// Revision               : 1.0
// ============================================================================
`default_nettype none

module hamming_nibble_encoder
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CW_W-1:0]   cw
);

    always_comb begin
        cw         = '0;
        cw[D3_POS] = data[3];
        cw[D2_POS] = data[2];
        cw[D1_POS] = data[1];
        cw[D0_POS] = data[0];
        cw[P2_POS] = data[3] ^ data[2] ^ data[1];
        cw[P1_POS] = data[2] ^ data[1] ^ data[0];
        cw[P0_POS] = data[3] ^ data[2] ^ data[0];
    end

endmodule

`default_nettype wire

// File: rtl/hamming_encoder_tx.sv
// ============================================================================
// hamming_encoder_tx : encodes a byte as two Hamming(7,4) codewords (low
//                      nibble first) and shifts them out MSB first
// Revision           : 1.0
// ============================================================================
`default_nettype none

module hamming_encoder_tx
    import hamming_pkg::*;
#(
    parameter int BIT_DIV = 1,
    parameter int GAP     = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            inj_en,
    input  logic [2:0]      inj_pos,
    output logic            tx_bit,
    output logic            tx_frame,
    output logic            tx_start,
    output logic [CW_W-1:0] cw_cur
);

    if (BIT_DIV < 1 || BIT_DIV > 255) begin : g_bad_bit_div
        $error("hamming_encoder_tx: BIT_DIV out of range 1..255");
    end
    if (GAP < 1 || GAP > 15) begin : g_bad_gap
        $error("hamming_encoder_tx: GAP out of range 1..15");
    end

    localparam logic [7:0] DIV_LAST = 8'(BIT_DIV - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    state_t          state, state_n;
    logic            nib_sel, nib_sel_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [7:0]      div_cnt, div_cnt_n;
    logic [3:0]      gap_cnt, gap_cnt_n;
    logic [CW_W-1:0] cw_hi, cw_hi_n;
    logic [CW_W-1:0] cw_cur_n;
    logic [CW_W-1:0] enc_lo, enc_hi, lo_inj;
    logic            accept;
    logic            frame_n, bit_n, start_n;

    hamming_nibble_encoder u_enc_lo (
        .data (in_data[3:0]),
        .cw   (enc_lo)
    );

    hamming_nibble_encoder u_enc_hi (
        .data (in_data[7:4]),
        .cw   (enc_hi)
    );

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;

    // inj_pos == 7 selects no bit, so the low codeword passes through clean
    always_comb begin
        lo_inj = enc_lo;
        if (inj_en && inj_pos != 3'd7) begin
            lo_inj[inj_pos] = ~enc_lo[inj_pos];
        end
    end

    always_comb begin
        state_n   = state;
        nib_sel_n = nib_sel;
        bit_idx_n = bit_idx;
        div_cnt_n = div_cnt;
        gap_cnt_n = gap_cnt;
        cw_hi_n   = cw_hi;
        cw_cur_n  = cw_cur;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n   = ST_SHIFT;
                    nib_sel_n = 1'b0;
                    bit_idx_n = 3'd6;
                    div_cnt_n = 8'd0;
                    cw_hi_n   = enc_hi;
                    cw_cur_n  = lo_inj;
                end
            end
            ST_SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_n = 8'd0;
                    if (bit_idx == 3'd0) begin
                        state_n   = ST_GAP;
                        gap_cnt_n = 4'd0;
                    end else begin
                        bit_idx_n = bit_idx - 3'd1;
                    end
                end else begin
                    div_cnt_n = div_cnt + 8'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (!nib_sel) begin
                        state_n   = ST_SHIFT;
                        nib_sel_n = 1'b1;
                        bit_idx_n = 3'd6;
                        div_cnt_n = 8'd0;
                        cw_cur_n  = cw_hi;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    gap_cnt_n = gap_cnt + 4'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Serial outputs are registered from next-state values so they line up with the FSM
    always_comb begin
        frame_n = (state_n == ST_SHIFT);
        bit_n   = frame_n && cw_cur_n[bit_idx_n];
        start_n = frame_n && (state != ST_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            nib_sel  <= 1'b0;
            bit_idx  <= 3'd0;
            div_cnt  <= 8'd0;
            gap_cnt  <= 4'd0;
            cw_hi    <= '0;
            cw_cur   <= '0;
            tx_bit   <= 1'b0;
            tx_frame <= 1'b0;
            tx_start <= 1'b0;
        end else begin
            state    <= state_n;
            nib_sel  <= nib_sel_n;
            bit_idx  <= bit_idx_n;
            div_cnt  <= div_cnt_n;
            gap_cnt  <= gap_cnt_n;
            cw_hi    <= cw_hi_n;
            cw_cur   <= cw_cur_n;
            tx_bit   <= bit_n;
            tx_frame <= frame_n;
            tx_start <= start_n;
        end
    end

endmodule

`default_nettype wire
